// File: rtl/ft2232_fifo_ctrl_pkg.sv
// Shared definitions for the FT2232 synchronous-FIFO bridge: bus width,
// parameter defaults and the bus controller state encoding.
package ft2232_fifo_ctrl_pkg;

    localparam int BUS_W          = 8;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_BURST_MAX  = 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX_TURN  = 3'd1,
        ST_RX_READ  = 3'd2,
        ST_RX_END   = 3'd3,
        ST_TX_WRITE = 3'd4
    } state_t;

endpackage

// File: rtl/ft2232_fifo_ctrl_fifo.sv
// Show-ahead synchronous byte FIFO with full/empty flags and free-entry count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_byte_fifo
    import ft2232_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [BUS_W-1:0]       push_data,
    input  logic                   pop,
    output logic [BUS_W-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] free
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BUS_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign free    = CW'(DEPTH) - count;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ft2232_fifo_ctrl.sv
// Bridge between the FT2232 245-style synchronous FIFO bus and two byte
// streams, arbitrating RX/TX bursts round-robin with bus turnaround cycles.
module ft2232_fifo_ctrl
    import ft2232_fifo_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int BURST_MAX  = DEF_BURST_MAX
) (
    input  logic             fifo_clk_i,
    input  logic             reset_n_i,
    input  logic             fifo_rxf_n_i,
    input  logic             fifo_txe_n_i,
    output logic             fifo_oe_n_o,
    output logic             fifo_rd_n_o,
    output logic             fifo_wr_n_o,
    output logic             fifo_siwu_o,
    inout  wire  [BUS_W-1:0] fifo_data_io,
    output logic [BUS_W-1:0] rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    input  logic [BUS_W-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BURST_MAX + 1);

    state_t          state, state_d;
    logic            oe_n, rd_n, wr_n, drive;
    logic            oe_n_d, rd_n_d, wr_n_d, drive_d;
    logic [BW-1:0]   burst, burst_d, burst_nx;
    logic            burst_hit;
    logic            prio_rx, prio_rx_d;

    logic            rx_cap, rx_pop, rx_full, rx_empty;
    logic [CW-1:0]   rx_free, rx_free_nx;
    logic            tx_push, tx_pop, tx_full, tx_empty, tx_last;
    logic [CW-1:0]   tx_free;
    logic [BUS_W-1:0] tx_head;
    logic            rx_req, tx_req;

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (fifo_clk_i),
        .rst_n     (reset_n_i),
        .push      (rx_cap),
        .push_data (fifo_data_io),
        .pop       (rx_pop),
        .head      (rx_data_o),
        .full      (rx_full),
        .empty     (rx_empty),
        .free      (rx_free)
    );

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (fifo_clk_i),
        .rst_n     (reset_n_i),
        .push      (tx_push),
        .push_data (tx_data_i),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .free      (tx_free)
    );

    assign rx_valid_o = !rx_empty;
    assign rx_pop     = rx_ready_i && !rx_empty;
    assign tx_ready_o = !tx_full;
    assign tx_push    = tx_valid_i && !tx_full;

    assign rx_cap = (state == ST_RX_READ) && !rd_n && !fifo_rxf_n_i && !rx_full;
    assign tx_pop = (state == ST_TX_WRITE) && !wr_n && !fifo_txe_n_i;

    // Free count after this edge; keeping two spare entries means the
    // byte already in flight on the next edge always has a slot.
    assign rx_free_nx = rx_free + CW'(rx_pop) - CW'(rx_cap);
    assign tx_last    = (tx_free == CW'(FIFO_DEPTH - 1)) && !tx_push;
    assign burst_nx   = burst + BW'(rx_cap || tx_pop);
    assign burst_hit  = (burst_nx >= BW'(BURST_MAX));

    assign rx_req = !fifo_rxf_n_i && (rx_free >= CW'(2));
    assign tx_req = !fifo_txe_n_i && !tx_empty;

    always_comb begin
        state_d   = state;
        burst_d   = burst;
        prio_rx_d = prio_rx;
        case (state)
            ST_IDLE: begin
                if (rx_req && (prio_rx || !tx_req)) begin
                    state_d   = ST_RX_TURN;
                    burst_d   = '0;
                    prio_rx_d = 1'b0;
                end else if (tx_req) begin
                    state_d   = ST_TX_WRITE;
                    burst_d   = '0;
                    prio_rx_d = 1'b1;
                end
            end
            ST_RX_TURN: state_d = ST_RX_READ;
            ST_RX_READ: begin
                burst_d = burst_nx;
                if (fifo_rxf_n_i || (rx_free_nx < CW'(2)) || burst_hit) state_d = ST_RX_END;
            end
            ST_RX_END: state_d = ST_IDLE;
            ST_TX_WRITE: begin
                burst_d = burst_nx;
                if (fifo_txe_n_i || (tx_pop && tx_last) || burst_hit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes are decoded from the next state so they leave a flop.
        oe_n_d  = !((state_d == ST_RX_TURN) || (state_d == ST_RX_READ));
        rd_n_d  = (state_d != ST_RX_READ);
        wr_n_d  = (state_d != ST_TX_WRITE);
        drive_d = (state_d == ST_TX_WRITE);
    end

    always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= ST_IDLE;
            oe_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            drive   <= 1'b0;
            burst   <= '0;
            prio_rx <= 1'b1;
        end else begin
            state   <= state_d;
            oe_n    <= oe_n_d;
            rd_n    <= rd_n_d;
            wr_n    <= wr_n_d;
            drive   <= drive_d;
            burst   <= burst_d;
            prio_rx <= prio_rx_d;
        end
    end

    assign fifo_oe_n_o  = oe_n;
    assign fifo_rd_n_o  = rd_n;
    assign fifo_wr_n_o  = wr_n;
    assign fifo_siwu_o  = 1'b1;

    // Tri-state bus; maps onto the bidirectional pad cells at synthesis.
    assign fifo_data_io = drive ? tx_head : {BUS_W{1'bz}};

endmodule
